// File: rtl/param_sequence_detector_if.sv
// Serial detector bus: bit stream, pattern programming and match status.
// The master side feeds bits and programs the pattern; the slave side is the detector.
interface param_sequence_detector_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             data_in;
  logic             data_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic             overlap_en;
  logic             count_clr;
  logic             data_out;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output data_in, data_valid, pat_load, pat_in, len_in, overlap_en, count_clr,
    input  data_out, match_count, count_sat
  );

  modport slave (
    input  data_in, data_valid, pat_load, pat_in, len_in, overlap_en, count_clr,
    output data_out, match_count, count_sat
  );
endinterface

// File: rtl/param_sequence_detector.sv
// Programmable serial bit-pattern detector with overlap control and a
// saturating match counter. All outputs are registered.
module param_sequence_detector #(
  parameter int               PAT_W     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(8'b10101011),
  parameter int               RESET_LEN = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  param_sequence_detector_if.slave bus
);
  localparam int               LEN_W       = $clog2(PAT_W) + 1;
  localparam logic [LEN_W-1:0] PAT_W_L     = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RESET_LEN_L = (RESET_LEN > PAT_W) ? PAT_W_L : LEN_W'(RESET_LEN);

  // Ones in the low n bit positions; selects the active part of the pattern.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] n);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (LEN_W'(i) < n);
    end
    return m;
  endfunction

  // Lengths above the history depth are clipped to the full depth.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    return (n > PAT_W_L) ? PAT_W_L : n;
  endfunction

  // Counter increment that sticks at all ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             data_out_r;
  logic [CNT_W-1:0] count_r;
  logic             sat_r;

  logic [PAT_W-1:0] h_next;
  logic [LEN_W-1:0] f_next;
  logic             hit;
  logic             match_now;
  logic [CNT_W-1:0] cnt_next;

  // Candidate history after this sample, match test and next counter value.
  always_comb begin
    h_next    = {hist[PAT_W-2:0], bus.data_in};
    f_next    = (fill == PAT_W_L) ? fill : fill + 1'b1;
    hit       = (len != '0) && (f_next >= len) &&
                (((h_next ^ pat) & len_mask(len)) == '0);
    match_now = hit && bus.data_valid && !bus.pat_load;
    if (bus.count_clr)
      cnt_next = '0;
    else if (match_now)
      cnt_next = sat_inc(count_r);
    else
      cnt_next = count_r;
  end

  // History/pattern state, match pulse and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist       <= '0;
      fill       <= '0;
      pat        <= RESET_PAT;
      len        <= RESET_LEN_L;
      data_out_r <= 1'b0;
      count_r    <= '0;
      sat_r      <= 1'b0;
    end else begin
      data_out_r <= 1'b0;
      count_r    <= cnt_next;
      sat_r      <= &cnt_next;
      if (bus.pat_load) begin
        // A new pattern restarts qualification; a same-edge sample is dropped.
        pat  <= bus.pat_in;
        len  <= clamp_len(bus.len_in);
        fill <= '0;
      end else if (bus.data_valid) begin
        hist <= h_next;
        if (hit) begin
          data_out_r <= 1'b1;
          // Non-overlapping mode keeps the bits but stops them counting.
          fill       <= bus.overlap_en ? f_next : '0;
        end else begin
          fill <= f_next;
        end
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.match_count = count_r;
  assign bus.count_sat   = sat_r;
endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector with a stream-level reference model.
module tb_param_sequence_detector;
  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam logic [23:0] S = 24'b11010101_00010110_10101011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  param_sequence_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  param_sequence_detector #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .RESET_PAT(8'b10101011), .RESET_LEN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: every sampled bit since reset, samples since the last
  // qualification restart, active pattern/length and expected outputs.
  bit         stream[$];
  int         since;
  logic [7:0] m_pat;
  int         m_len;
  bit         exp_out;
  int         exp_cnt;
  bit         ov = 1'b1;
  int         dut_pulses, mdl_pulses, dut_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    stream.delete();
    since   = 0;
    m_pat   = 8'b10101011;
    m_len   = 8;
    exp_out = 1'b0;
    exp_cnt = 0;
  endfunction

  // Bit i places back from the newest sample (i=0 is the bit on this edge).
  function automatic bit getbit(input bit din, input int i);
    if (i == 0) return din;
    return stream[stream.size() - i];
  endfunction

  task automatic step(input bit din, input bit dv, input bit load, input logic [7:0] pin,
                      input logic [3:0] lin, input bit clr, input int idx);
    bit         hit;
    int         n_since, n_len, n_cnt;
    logic [7:0] n_pat;
    hit     = 1'b0;
    n_since = since;
    n_len   = m_len;
    n_pat   = m_pat;
    bus.data_in    = din;
    bus.data_valid = dv;
    bus.pat_load   = load;
    bus.pat_in     = pin;
    bus.len_in     = lin;
    bus.overlap_en = ov;
    bus.count_clr  = clr;
    if (load) begin
      n_pat   = pin;
      n_len   = (int'(lin) > PAT_W) ? PAT_W : int'(lin);
      n_since = 0;
    end else if (dv) begin
      n_since = since + 1;
      if (m_len != 0 && n_since >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (getbit(din, i) != m_pat[i]) hit = 1'b0;
      end
      if (hit && !ov) n_since = 0;
    end
    n_cnt = clr ? 0 : (hit ? ((exp_cnt == 3) ? 3 : exp_cnt + 1) : exp_cnt);
    @(posedge clk);
    if (!load && dv) stream.push_back(din);
    since   = n_since;
    m_pat   = n_pat;
    m_len   = n_len;
    exp_out = hit;
    exp_cnt = n_cnt;
    if (hit) mdl_pulses++;
    #1;
    if (bus.data_out === 1'b1) begin
      dut_pulses++;
      dut_last = idx;
    end
  endtask

  task automatic load(input logic [7:0] pin, input logic [3:0] lin);
    step(1'b0, 1'b1, 1'b1, pin, lin, 1'b0, -1);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, -1);
  endtask

  task automatic feed(input logic [23:0] s, input int n, input bit gaps);
    dut_pulses = 0;
    mdl_pulses = 0;
    dut_last   = -1;
    for (int i = 0; i < n; i++) begin
      step(s[n-1-i], 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, i);
      if (gaps) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, -1);
    end
  endtask

  task automatic expect_run(input string name, input int pulses, input int last, input int cnt);
    check({name, "_dut_pulses"}, 32'(dut_pulses), 32'(pulses));
    check({name, "_model_pulses"}, 32'(mdl_pulses), 32'(pulses));
    check({name, "_last_pulse"}, 32'(dut_last), 32'(last));
    check({name, "_count"}, 32'(bus.match_count), 32'(cnt));
  endtask

  // Cycle-by-cycle comparison against the model, half a period after each edge.
  always @(negedge clk) begin
    check("data_out", 32'(bus.data_out), 32'(exp_out));
    check("match_count", 32'(bus.match_count), 32'(exp_cnt));
    check("count_sat", 32'(bus.count_sat), 32'(exp_cnt == 3));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.data_in = 1'b0; bus.data_valid = 1'b0; bus.pat_load = 1'b0; bus.pat_in = '0;
    bus.len_in = '0; bus.overlap_en = 1'b1; bus.count_clr = 1'b0;
    #30 rst_n = 1'b1;
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    check("reset_count", 32'(bus.match_count), 32'd0);
    check("reset_sat", 32'(bus.count_sat), 32'd0);

    // Default pattern 10101011, len 8
    feed(S, 24, 1'b0);
    expect_run("default", 1, 23, 1);

    // Runtime load 1011, len 4
    load(8'h0B, 4'd4); clear();
    feed(S, 24, 1'b0);
    expect_run("len4", 2, 23, 2);

    // Overlapping vs non-overlapping on 10101 with pattern 101
    ov = 1'b1; load(8'h05, 4'd3); clear();
    feed(24'h15, 5, 1'b0);
    expect_run("overlap", 2, 4, 2);
    ov = 1'b0; load(8'h05, 4'd3); clear();
    feed(24'h15, 5, 1'b0);
    expect_run("nonoverlap", 1, 2, 1);
    ov = 1'b1;

    // Alternate-cycle valid gaps
    load(8'h0B, 4'd4); clear();
    feed(S, 24, 1'b1);
    expect_run("gaps", 2, 23, 2);

    // Saturation with a 2-bit counter, then clear colliding with a match
    load(8'h01, 4'd1); clear();
    feed(24'h1F, 5, 1'b0);
    expect_run("sat", 5, 4, 3);
    check("sat_flag", 32'(bus.count_sat), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 99);
    check("clr_wins_count", 32'(bus.match_count), 32'd0);
    check("clr_wins_sat", 32'(bus.count_sat), 32'd0);
    check("clr_wins_pulse", 32'(bus.data_out), 32'd1);

    // Reload after 3 of 4 bits discards the partial history
    load(8'h0B, 4'd4); clear();
    feed(24'h5, 3, 1'b0);
    load(8'h0B, 4'd4);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 0);
    check("reload_no_match", 32'(bus.data_out), 32'd0);

    // Asynchronous reset mid-stream restores the reset pattern
    load(8'h01, 4'd1);
    feed(24'h1, 1, 1'b0);
    check("pre_reset_pulse", 32'(bus.data_out), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_data_out", 32'(bus.data_out), 32'd0);
    check("async_rst_count", 32'(bus.match_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    feed(S, 24, 1'b0);
    expect_run("post_reset", 1, 23, 1);

    // Length 0 disables detection
    load(8'h00, 4'd0); clear();
    feed(24'h0, 24, 1'b0);
    expect_run("len0_zeros", 0, -1, 0);
    feed(S, 24, 1'b0);
    expect_run("len0_stream", 0, -1, 0);

    // Oversized length is clipped to the full depth
    load(8'hAB, 4'd15); clear();
    feed(S, 24, 1'b0);
    expect_run("len_clip", 1, 23, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/param_sequence_detector.md
# param_sequence_detector

Parametrised serial bit-pattern detector: samples a 1-bit stream on qualified cycles and pulses `data_out` each time the most recent bits equal a runtime-loadable pattern of programmable length (1..PAT_W). Overlapping or non-overlapping matching is selectable, and a saturating match counter is provided. It generalises the fixed single-pattern sequence detector and sits in the same serial front end, directly after the bit source.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `CNT_W`, default 8: width of the match counter.
- `RESET_PAT`, default 8'b10101011 (PAT_W bits): pattern after reset.
- `RESET_LEN`, default 8: pattern length after reset.
- Derived `LEN_W` = $clog2(PAT_W)+1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `data_in`, in, 1: serial bit, sampled only when `data_valid`=1.
- `data_valid`, in, 1: qualifies `data_in`.
- `pat_load`, in, 1: load `pat_in`/`len_in` this edge.
- `pat_in`, in, PAT_W: new pattern, right-justified; bit len-1 is the first bit expected.
- `len_in`, in, LEN_W: new pattern length.
- `overlap_en`, in, 1: 1 = overlapping matches, 0 = non-overlapping.
- `count_clr`, in, 1: synchronous clear of `match_count`.
- `data_out`, out, 1: one-cycle match pulse.
- `match_count`, out, CNT_W: number of matches since reset or clear.
- `count_sat`, out, 1: high while `match_count` is all ones.

## Operation
- State registers:
  - `hist` (PAT_W): newest bit at bit 0, shifted left on every valid sample.
  - `fill` (0..PAT_W): number of valid bits in history, saturating at PAT_W.
  - `pat`, `len`: active pattern and length.
- Reset values:
  - `hist`=0, `fill`=0, `pat`=RESET_PAT, `len`=RESET_LEN.
  - `data_out`=0, `match_count`=0, `count_sat`=0.
- Valid edge (`data_valid`=1, `pat_load`=0):
  - Form `h' = {hist[PAT_W-2:0], data_in}` and `f' = min(fill+1, PAT_W)`.
  - Match = `len`≠0 AND `f'` ≥ `len` AND `h'[len-1:0] == pat[len-1:0]`.
  - On match: set `data_out`=1 for one cycle.
  - If `overlap_en`=0, also set `fill`=0 (history bits are kept but no longer count).
  - No match: `data_out`=0, `hist`=h', `fill`=f'.
- Non-valid edge: `hist` and `fill` hold; `data_out`=0.
- Pattern load (`pat_load`=1):
  - `pat` ← `pat_in`; `len` ← min(`len_in`, PAT_W).
  - `fill` ← 0 and `data_out` ← 0.
  - `data_valid` on the same edge is ignored.
  - `len_in`=0 disables detection: no match is possible until a nonzero length is loaded.
- `overlap_en` is sampled every edge and may change at any time. A change affects only the next match.
- Counter:
  - Increments by 1 on each match edge; saturates at 2^CNT_W−1.
  - `count_sat` = (`match_count` == all ones), registered together with the count.
  - If `count_clr` and a match occur on the same edge, the clear wins and the count becomes 0.
- Reset mid-stream immediately forces every register to its reset value. The pattern reverts to RESET_PAT/RESET_LEN.

## Timing
- Latency: `data_out` is high during the clock cycle after the edge that samples the last pattern bit, for exactly 1 cycle.
- `match_count` updates on that same edge, so it is coincident with the `data_out` pulse.
- Back-to-back matches are possible: with `overlap_en`=1 and a length-1 pattern, `data_out` may stay high on consecutive valid cycles.
- Throughput: 1 bit per clock; `data_valid` gaps of any length are transparent.
- A newly loaded pattern can match no earlier than `len` valid samples after the load edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset/default:** release `rst_n` after 30 ns, then apply stream 11010101_00010110_10101011 MSB-first with `data_valid`=1 → exactly one `data_out` pulse, in the cycle after bit 23 is sampled; `match_count`=1.
- **Runtime load with length 4:** load `pat_in`=4'b1011, `len_in`=4, then apply the same 24-bit stream → pulses after bits 14 and 23; `match_count`=2.
- **Overlap mode:** load 3'b101, len 3, then apply stream 10101 → with `overlap_en`=1, pulses after bits 2 and 4, count 2; with `overlap_en`=0, one pulse after bit 2, count 1.
- **Valid gaps:** apply the length-4 1011 stream with `data_valid` low on alternate cycles → same 2 matches; each pulse is 1 cycle wide and 1 cycle after the qualifying edge.
- **Saturation and clear:** with CNT_W=2, drive 5 matches → `match_count` sticks at 3 and `count_sat`=1. Assert `count_clr` on a match edge → count 0, `count_sat`=0.
- **Mid-operation events:** assert `pat_load` after 3 of the 4 pattern bits → no match from the old partial history. Pulse `rst_n` low mid-stream → all outputs go to 0 asynchronously and the pattern reverts to 10101011, len 8. Load `len_in`=0 → no matches for any stream.
